fft_stream_checker: RTL and testbench

- Synthesizable, parametrised self-check block for the parallel FFT datapath.
- Compares LANES complex output lanes of topfft against an expected stream, such as a golden ROM or the Matlab-derived stream replayed from BRAM.
- A programmable delay line aligns the expected stream to the DUT pipeline latency. Counts frames and mismatches, latches the location of the first error, and reports pass/fail, so both simulation and on-board tests use the same checker.

---
 rtl/fft_stream_checker.sv | 123 ++++++++++++
 tb/tb_fft_stream_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fft_stream_checker.sv
// fft_stream_checker: compares LANES complex FFT output lanes against a delay-aligned expected stream,
// counting frames and mismatching beats and latching where the first error occurred.
module fft_stream_checker #(
   parameter int NBITS_out = 10,
   parameter int LANES = 4,
   parameter int N = 128,
   parameter int MAX_DLY = 32,
   parameter int CNT_W = 16,
   localparam int LW = 2 * NBITS_out,
   localparam int W = LANES * LW,
   localparam int BEATS = N / LANES,
   localparam int BW = $clog2(BEATS),
   localparam int DW = $clog2(MAX_DLY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_frames,
   input  logic [DW-1:0]    align_dly,
   input  logic             exp_valid,
   input  logic [W-1:0]     exp_data,
   input  logic             dut_valid,
   input  logic [W-1:0]     dut_data,
   output logic [LANES-1:0] lane_ok,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] first_err_frame,
   output logic [BW-1:0]    first_err_beat,
   output logic [LANES-1:0] first_err_lanes,
   output logic             unexpected,
   output logic             busy,
   output logic             done,
   output logic             pass
);
   typedef enum logic [1:0] {sIdle, sRun, sDone} stateT;
   stateT state, nextState;
   logic [CNT_W-1:0] numFrames;
   logic [DW-1:0] alignDly, dlyClamp;
   logic [MAX_DLY-2:0] dlyV;
   logic [W-1:0] dlyD [MAX_DLY-1];
   logic dexpV;
   logic [W-1:0] dexpD;
   logic [LANES-1:0] failMask;
   logic [BW-1:0] beat;
   logic arm, cmp, lastBeat, lastFrame;

   assign arm = start && state != sRun;
   assign cmp = state == sRun && dexpV;
   assign lastBeat = beat == BW'(BEATS - 1);
   assign lastFrame = frame_cnt + 1'b1 == numFrames;
   assign dlyClamp = int'(align_dly) > MAX_DLY - 1 ? DW'(MAX_DLY - 1) : align_dly;
   // a zero delay taps the live input so the expected beat lands in the same cycle
   assign dexpV = alignDly == '0 ? exp_valid : dlyV[alignDly - 1'b1];
   assign dexpD = alignDly == '0 ? exp_data : dlyD[alignDly - 1'b1];
   assign pass = done && err_cnt == '0 && !unexpected;

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= sIdle;
      else state <= nextState;

   always_comb
      nextState = arm ? sRun : (cmp && lastBeat && lastFrame) ? sDone : state;

   always_comb begin
      busy = state == sRun;
      done = state == sDone;
   end

   always_comb begin
      failMask = '0;
      for (int i = 0; i < LANES; i++)
         failMask[i] = !dut_valid || dut_data[i*LW +: LW] != dexpD[i*LW +: LW];
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) dlyV <= '0;
      else if (arm) dlyV <= '0;
      else if (state == sRun) dlyV <= (dlyV << 1) | (MAX_DLY - 1)'(exp_valid);

   // data stages carry no reset: their valid bits alone decide whether they are used
   always_ff @(posedge clk)
      if (state == sRun) begin
         dlyD[0] <= exp_data;
         for (int i = 1; i < MAX_DLY - 1; i++) dlyD[i] <= dlyD[i-1];
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         numFrames <= '0;
         alignDly <= '0;
         beat <= '0;
         lane_ok <= '1;
         err_cnt <= '0;
         frame_cnt <= '0;
         first_err_frame <= '0;
         first_err_beat <= '0;
         first_err_lanes <= '0;
         unexpected <= 1'b0;
      end else if (arm) begin
         numFrames <= num_frames == '0 ? CNT_W'(1) : num_frames;
         alignDly <= dlyClamp;
         beat <= '0;
         err_cnt <= '0;
         frame_cnt <= '0;
         first_err_frame <= '0;
         first_err_beat <= '0;
         first_err_lanes <= '0;
         unexpected <= 1'b0;
      end else if (state == sRun) begin
         if (cmp) begin
            lane_ok <= ~failMask;
            beat <= lastBeat ? '0 : beat + 1'b1;
            if (lastBeat) frame_cnt <= frame_cnt + 1'b1;
            if (|failMask && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (|failMask && err_cnt == '0) begin
               first_err_frame <= frame_cnt;
               first_err_beat <= beat;
               first_err_lanes <= failMask;
            end
         end
         if (dut_valid && !dexpV) unexpected <= 1'b1;
      end
endmodule

// File: tb/tb_fft_stream_checker.sv
// tb_fft_stream_checker: directed streams checked every cycle against a queue-based model
// of the checker, plus literal expectations for each scenario.
module tb_fft_stream_checker;
   localparam int LANES = 4, LW = 20, W = 80, BEATS = 32, CW = 16;
   localparam logic [W-1:0] FLIP = W'(1) << 40;

   logic clk = 0, rst = 0, start = 0, exp_valid = 0, dut_valid = 0;
   logic [CW-1:0] num_frames = 0;
   logic [4:0] align_dly = 0;
   logic [W-1:0] exp_data = 0, dut_data = 0;
   logic [LANES-1:0] lane_ok, first_err_lanes;
   logic [CW-1:0] err_cnt, frame_cnt, first_err_frame;
   logic [4:0] first_err_beat;
   logic unexpected, busy, done, pass;

   int nVec = 0, nErr = 0;

   always #5 clk = ~clk;

   fft_stream_checker dut (
      .clk(clk), .rst(rst), .start(start), .num_frames(num_frames), .align_dly(align_dly),
      .exp_valid(exp_valid), .exp_data(exp_data), .dut_valid(dut_valid), .dut_data(dut_data),
      .lane_ok(lane_ok), .err_cnt(err_cnt), .frame_cnt(frame_cnt),
      .first_err_frame(first_err_frame), .first_err_beat(first_err_beat),
      .first_err_lanes(first_err_lanes), .unexpected(unexpected), .busy(busy), .done(done),
      .pass(pass)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         if (nErr <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] gen(input int k);
      logic [W-1:0] d;
      for (int i = 0; i < LANES; i++) d[i*LW +: LW] = {10'(k * 7 + i * 3), 10'(k * 13 + i * 5 + 1)};
      return d;
   endfunction

   // model: 0 idle, 1 run, 2 done; the expected-stream delay is a FIFO of exactly mDly entries
   int mState, mNum, mDly, mBeat, mFrame, mErr, mFirstF, mFirstB;
   logic [3:0] mFirstL, mLaneOk, mF;
   bit mUnexp, mDv;
   logic [W-1:0] mDd;
   bit histV[$];
   logic [W-1:0] histD[$];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mState = 0; mNum = 0; mDly = 0; mBeat = 0; mFrame = 0; mErr = 0;
         mFirstF = 0; mFirstB = 0; mFirstL = 0; mLaneOk = 4'hf; mUnexp = 0;
         histV.delete(); histD.delete();
      end else if (mState == 1) begin
         if (mDly == 0) begin
            mDv = exp_valid; mDd = exp_data;
         end else begin
            mDv = histV.pop_front(); mDd = histD.pop_front();
            histV.push_back(exp_valid); histD.push_back(exp_data);
         end
         if (mDv) begin
            for (int i = 0; i < LANES; i++) mF[i] = !(dut_valid && dut_data[i*LW +: LW] == mDd[i*LW +: LW]);
            mLaneOk = ~mF;
            if (mF != 0) begin
               if (mErr == 0) begin mFirstF = mFrame; mFirstB = mBeat; mFirstL = mF; end
               if (mErr < 65535) mErr++;
            end
            mBeat++;
            if (mBeat == BEATS) begin
               mBeat = 0; mFrame++;
               if (mFrame == mNum) mState = 2;
            end
         end else if (dut_valid) mUnexp = 1;
      end else if (start) begin
         mState = 1; mNum = num_frames == 0 ? 1 : int'(num_frames); mDly = int'(align_dly);
         mBeat = 0; mFrame = 0; mErr = 0; mFirstF = 0; mFirstB = 0; mFirstL = 0; mUnexp = 0;
         histV.delete(); histD.delete();
         repeat (mDly) begin histV.push_back(0); histD.push_back('0); end
      end
   end

   always @(negedge clk) begin
      chk("busy", busy, mState == 1);
      chk("done", done, mState == 2);
      chk("pass", pass, mState == 2 && mErr == 0 && !mUnexp);
      chk("err_cnt", err_cnt, mErr);
      chk("frame_cnt", frame_cnt, mFrame);
      chk("lane_ok", lane_ok, mLaneOk);
      chk("first_err_frame", first_err_frame, mFirstF);
      chk("first_err_beat", first_err_beat, mFirstB);
      chk("first_err_lanes", first_err_lanes, mFirstL);
      chk("unexpected", unexpected, mUnexp);
   end

   task automatic armRun(input int nf, input int dly);
      num_frames = CW'(nf); align_dly = 5'(dly); start = 1;
      @(posedge clk); #1 start = 0;
   endtask

   task automatic drive(input int nBeats, input int dly, input int flipK, input int dropK,
                        input int unexpC, input bit allDrop, input int rstC);
      for (int c = 0; c < nBeats + dly + 4; c++) begin
         int k = c - dly;
         exp_valid = c < nBeats;
         exp_data = c < nBeats ? gen(c) : '0;
         dut_valid = (!allDrop && k >= 0 && k < nBeats && k != dropK) || c == unexpC;
         dut_data = (k >= 0 && k < nBeats) ? gen(k) ^ (k == flipK ? FLIP : '0) : '0;
         if (c == rstC) begin
            #2 rst = 0;
            @(negedge clk);
            chk("rst busy", busy, 0);
            chk("rst err_cnt", err_cnt, 0);
            chk("rst frame_cnt", frame_cnt, 0);
            chk("rst lane_ok", lane_ok, 4'b1111);
            @(posedge clk); #1 rst = 1;
            exp_valid = 0; dut_valid = 0;
            return;
         end
         @(posedge clk); #1;
      end
      exp_valid = 0; dut_valid = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset lane_ok", lane_ok, 4'b1111);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset err_cnt", err_cnt, 0);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1;

      armRun(2, 3); drive(64, 3, -1, -1, -1, 0, -1);
      @(negedge clk);
      chk("clean done", done, 1); chk("clean pass", pass, 1);
      chk("clean err_cnt", err_cnt, 0); chk("clean frame_cnt", frame_cnt, 2);
      chk("model clean frames", mFrame, 2);

      armRun(2, 3); drive(64, 3, 37, -1, -1, 0, -1);
      @(negedge clk);
      chk("flip err_cnt", err_cnt, 1); chk("flip first_frame", first_err_frame, 1);
      chk("flip first_beat", first_err_beat, 5); chk("flip first_lanes", first_err_lanes, 4'b0100);
      chk("flip pass", pass, 0); chk("flip done", done, 1);
      chk("model flip lanes", mFirstL, 4'b0100);

      armRun(2, 0); drive(64, 0, -1, 10, -1, 0, -1);
      @(negedge clk);
      chk("drop err_cnt", err_cnt, 1); chk("drop first_lanes", first_err_lanes, 4'b1111);
      chk("drop first_beat", first_err_beat, 10); chk("drop first_frame", first_err_frame, 0);

      armRun(2, 3); drive(64, 3, -1, -1, 1, 0, -1);
      @(negedge clk);
      chk("unexp flag", unexpected, 1); chk("unexp err_cnt", err_cnt, 0);
      chk("unexp pass", pass, 0); chk("unexp done", done, 1);

      armRun(0, 1); drive(32, 1, -1, -1, -1, 0, -1);
      @(negedge clk);
      chk("nf0 frame_cnt", frame_cnt, 1); chk("nf0 pass", pass, 1);

      armRun(2188, 0); drive(70016, 0, -1, -1, -1, 1, -1);
      @(negedge clk);
      chk("sat err_cnt", err_cnt, 65535); chk("sat done", done, 1);
      chk("sat frame_cnt", frame_cnt, 2188); chk("model sat err", mErr, 65535);

      armRun(1, 0);
      @(negedge clk);
      chk("rearm busy", busy, 1); chk("rearm err_cnt", err_cnt, 0);
      chk("rearm frame_cnt", frame_cnt, 0); chk("rearm first_lanes", first_err_lanes, 0);
      @(posedge clk); #1;
      drive(32, 0, -1, -1, -1, 0, -1);
      @(negedge clk);
      chk("rearm pass", pass, 1);

      armRun(2, 3); drive(64, 3, 19, -1, -1, 0, 23);
      @(posedge clk); #1;
      armRun(2, 3); drive(64, 3, -1, -1, -1, 0, -1);
      @(negedge clk);
      chk("post-rst pass", pass, 1); chk("post-rst frame_cnt", frame_cnt, 2);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

   initial begin
      #5000000;
      nErr++;
      $display("FAIL watchdog: run did not complete");
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
